// File: rtl/ioctl_loader.sv
// ioctl_loader: packs ioctl byte stream into DW-bit words, queues them in a
// small FIFO and hands them to one of NCH targets with a req/ack handshake.
// Ports:
//   clk_sys, rstn              clock, synchronous active-low reset
//   ioctl_download/index/wr    byte source control (channel = index < NCH)
//   ioctl_addr/dout            byte address and data
//   ioctl_wait                 back-pressure to the byte source
//   ldr_addr/wdat/be           head word presented to the target
//   ldr_wr/ldr_ack             one-hot request, per-channel acknowledge
//   ldr_done                   per-channel sticky completion flag
//   ovf                        sticky FIFO overflow flag
module ioctl_loader #(
  parameter int DW    = 16,
  parameter int AW    = 20,
  parameter int DEPTH = 4,
  parameter int NCH   = 4
) (
  input  logic            clk_sys,
  input  logic            rstn,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic [AW-1:0]   ldr_addr,
  output logic [DW-1:0]   ldr_wdat,
  output logic [DW/8-1:0] ldr_be,
  output logic [NCH-1:0]  ldr_wr,
  input  logic [NCH-1:0]  ldr_ack,
  output logic [NCH-1:0]  ldr_done,
  output logic            ovf
);

  localparam int BPW = DW / 8;
  localparam int LW  = $clog2(BPW);
  localparam int LWI = (LW > 0) ? LW : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  // download tracking
  logic           dl_q;
  logic [CHW-1:0] ch_q;
  logic           ch_ok;
  logic           pend;
  logic           rise;
  logic           fall;
  logic           idx_ok;
  logic           cur_ok;
  logic [CHW-1:0] cur_ch;
  logic           acc;

  // byte decode
  logic [LWI-1:0] lane;
  logic [AW-1:0]  waddr;
  logic           last;

  // packer
  logic           pk_valid, pk_valid_n;
  logic           pk_full, pk_full_n;
  logic [AW-1:0]  pk_addr, pk_addr_n;
  logic [DW-1:0]  pk_data, pk_data_n;
  logic [BPW-1:0] pk_be, pk_be_n;
  logic [CHW-1:0] pk_ch, pk_ch_n;
  logic           flush_old;
  logic [DW-1:0]  base_data, nw_data;
  logic [BPW-1:0] base_be, nw_be;

  // flush stage
  logic           fl_valid, fl_go;
  logic [AW-1:0]  fl_addr, fl_addr_n;
  logic [DW-1:0]  fl_data, fl_data_n;
  logic [BPW-1:0] fl_be, fl_be_n;
  logic [CHW-1:0] fl_ch, fl_ch_n;

  // fifo
  logic [AW-1:0]  mem_addr [DEPTH];
  logic [DW-1:0]  mem_data [DEPTH];
  logic [BPW-1:0] mem_be   [DEPTH];
  logic [CHW-1:0] mem_ch   [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           push_ok;
  logic           pop;

  // output side
  state_t         state, state_n;
  logic           load;
  logic [CHW-1:0] req_ch;
  logic [NCH-1:0] ack_q;
  logic           ack_rise;
  logic           quiet;

  logic           unused;
  assign unused = &{1'b0, ioctl_addr};

  if (LW > 0) begin : g_lane
    assign lane = ioctl_addr[LW-1:0];
  end else begin : g_nolane
    assign lane = '0;
  end

  assign waddr  = ioctl_addr[AW+LW-1:LW];
  assign last   = (lane == LWI'(BPW - 1));
  assign rise   = ioctl_download & ~dl_q;
  assign fall   = ~ioctl_download & dl_q;
  assign idx_ok = ({1'b0, ioctl_index} < 9'(NCH));
  assign cur_ok = rise ? idx_ok : ch_ok;
  assign cur_ch = rise ? ioctl_index[CHW-1:0] : ch_q;
  assign acc    = ioctl_download & ioctl_wr & cur_ok;

  // held word leaves when full, on address change or at end of download
  assign flush_old = pk_valid &
    (pk_full | fall | (acc & (pk_addr != waddr)));

  always_comb begin
    base_data  = pk_data;
    base_be    = pk_be;
    if (flush_old | ~pk_valid) begin
      base_data = '0;
      base_be   = '0;
    end
    nw_data    = base_data;
    nw_data[8*lane +: 8] = ioctl_dout;
    nw_be      = base_be;
    nw_be[lane] = 1'b1;

    pk_valid_n = pk_valid;
    pk_full_n  = pk_full;
    pk_addr_n  = pk_addr;
    pk_data_n  = pk_data;
    pk_be_n    = pk_be;
    pk_ch_n    = pk_ch;
    fl_go      = 1'b0;
    fl_addr_n  = pk_addr;
    fl_data_n  = pk_data;
    fl_be_n    = pk_be;
    fl_ch_n    = pk_ch;

    if (flush_old) begin
      fl_go      = 1'b1;
      pk_valid_n = 1'b0;
      pk_full_n  = 1'b0;
    end

    if (acc) begin
      if (last & ~flush_old) begin
        // completing byte goes straight to the flush stage
        fl_go      = 1'b1;
        fl_addr_n  = waddr;
        fl_data_n  = nw_data;
        fl_be_n    = nw_be;
        fl_ch_n    = cur_ch;
        pk_valid_n = 1'b0;
        pk_full_n  = 1'b0;
      end else begin
        // a full new word behind a flush waits one cycle in the packer
        pk_valid_n = 1'b1;
        pk_full_n  = last;
        pk_addr_n  = waddr;
        pk_data_n  = nw_data;
        pk_be_n    = nw_be;
        pk_ch_n    = cur_ch;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rstn) begin
      pk_valid <= 1'b0;
      pk_full  <= 1'b0;
      pk_addr  <= '0;
      pk_data  <= '0;
      pk_be    <= '0;
      pk_ch    <= '0;
      fl_valid <= 1'b0;
      fl_addr  <= '0;
      fl_data  <= '0;
      fl_be    <= '0;
      fl_ch    <= '0;
    end else begin
      pk_valid <= pk_valid_n;
      pk_full  <= pk_full_n;
      pk_addr  <= pk_addr_n;
      pk_data  <= pk_data_n;
      pk_be    <= pk_be_n;
      pk_ch    <= pk_ch_n;
      fl_valid <= fl_go;
      fl_addr  <= fl_addr_n;
      fl_data  <= fl_data_n;
      fl_be    <= fl_be_n;
      fl_ch    <= fl_ch_n;
    end
  end

  assign full       = (count == CW'(DEPTH));
  assign push_ok    = fl_valid & ~full;
  assign ioctl_wait = (count >= CW'(DEPTH - 1)) | (fl_valid & full);

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem_addr[wr_ptr] <= fl_addr;
      mem_data[wr_ptr] <= fl_data;
      mem_be[wr_ptr]   <= fl_be;
      mem_ch[wr_ptr]   <= fl_ch;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok & ~pop)
        count <= count + 1'b1;
      else if (~push_ok & pop)
        count <= count - 1'b1;
      if (fl_valid & full)
        ovf <= 1'b1;
    end
  end

  assign ack_rise = ldr_ack[req_ch] & ~ack_q[req_ch];

  always_comb begin
    state_n = state;
    load    = 1'b0;
    pop     = 1'b0;
    ldr_wr  = '0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_n = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
        ldr_wr[req_ch] = 1'b1;
        if (ack_rise) begin
          pop     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rstn) begin
      state    <= IDLE;
      ack_q    <= '0;
      req_ch   <= '0;
      ldr_addr <= '0;
      ldr_wdat <= '0;
      ldr_be   <= '0;
    end else begin
      state <= state_n;
      ack_q <= ldr_ack;
      if (load) begin
        req_ch   <= mem_ch[rd_ptr];
        ldr_addr <= mem_addr[rd_ptr];
        ldr_wdat <= mem_data[rd_ptr];
        ldr_be   <= mem_be[rd_ptr];
      end
    end
  end

  assign quiet = ~pk_valid & ~fl_valid &
    (count == '0) & (state == IDLE);

  always_ff @(posedge clk_sys) begin
    if (!rstn) begin
      dl_q     <= 1'b0;
      ch_q     <= '0;
      ch_ok    <= 1'b0;
      pend     <= 1'b0;
      ldr_done <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (rise) begin
        ch_q  <= cur_ch;
        ch_ok <= idx_ok;
        pend  <= idx_ok;
        if (idx_ok)
          ldr_done[cur_ch] <= 1'b0;
      end else if (pend & ~ioctl_download & quiet) begin
        ldr_done[ch_q] <= 1'b1;
        pend           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed bench for ioctl_loader, a DW=16 instance
// plus a DW=32 instance sharing the byte-source inputs.
module tb_ioctl_loader;

  logic        clk;
  logic        rstn;
  logic        dl;
  logic [7:0]  idx;
  logic        wr;
  logic [24:0] addr;
  logic [7:0]  dout;

  logic        wt;
  logic [19:0] laddr;
  logic [15:0] wdat;
  logic [1:0]  be;
  logic [3:0]  lwr;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        ovf;

  logic        wt32;
  logic [19:0] laddr32;
  logic [31:0] wdat32;
  logic [3:0]  be32;
  logic [3:0]  lwr32;
  logic [3:0]  ack32;
  logic [3:0]  done32;
  logic        ovf32;

  int n_chk;
  int n_fail;
  int sent;
  int first_wait;

  ioctl_loader u_dut (
    .clk_sys(clk), .rstn(rstn), .ioctl_download(dl),
    .ioctl_index(idx), .ioctl_wr(wr), .ioctl_addr(addr),
    .ioctl_dout(dout), .ioctl_wait(wt), .ldr_addr(laddr),
    .ldr_wdat(wdat), .ldr_be(be), .ldr_wr(lwr),
    .ldr_ack(ack), .ldr_done(done), .ovf(ovf)
  );

  ioctl_loader #(.DW(32)) u_dut32 (
    .clk_sys(clk), .rstn(rstn), .ioctl_download(dl),
    .ioctl_index(idx), .ioctl_wr(wr), .ioctl_addr(addr),
    .ioctl_dout(dout), .ioctl_wait(wt32), .ldr_addr(laddr32),
    .ldr_wdat(wdat32), .ldr_be(be32), .ldr_wr(lwr32),
    .ldr_ack(ack32), .ldr_done(done32), .ovf(ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    dl    = 1'b0;
    idx   = 8'd0;
    wr    = 1'b0;
    addr  = '0;
    dout  = '0;
    ack   = '0;
    ack32 = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic send_byte(input logic [24:0] a,
                           input logic [7:0] d);
    wr   = 1'b1;
    addr = a;
    dout = d;
    tick();
    wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] i);
    idx = i;
    dl  = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // reset state
    do_reset();
    rstn = 1'b0;
    tick();
    check("rst_wait", wt, 0);
    check("rst_wr", lwr, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_addr", laddr, 0);
    check("rst_wdat", wdat, 0);
    check("rst_be", be, 0);
    rstn = 1'b1;

    // basic word on channel 1, latency and done
    start_dl(8'd1);
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    check("lat_e0", lwr, 0);
    tick();
    check("lat_e1", lwr, 0);
    tick();
    check("b_wr", lwr, 4'b0010);
    check("b_addr", laddr, 0);
    check("b_wdat", wdat, 16'h2211);
    check("b_be", be, 2'b11);
    tick();
    tick();
    tick();
    check("b_hold", lwr, 4'b0010);
    ack[1] = 1'b1;
    tick();
    check("b_pop", lwr, 0);
    ack[1] = 1'b0;
    check("b_nodone", done, 0);
    dl = 1'b0;
    tick();
    check("b_done", done, 4'b0010);

    // DW=32 partial word flushed by end of download
    do_reset();
    start_dl(8'd2);
    send_byte(25'd4, 8'hAA);
    send_byte(25'd5, 8'hBB);
    tick();
    tick();
    check("p32_held", lwr32, 0);
    dl = 1'b0;
    tick();
    tick();
    tick();
    check("p32_wr", lwr32, 4'b0100);
    check("p32_addr", laddr32, 1);
    check("p32_be", be32, 4'b0011);
    check("p32_wdat", wdat32, 32'h0000BBAA);
    ack32[2] = 1'b1;
    tick();
    tick();
    check("p32_done", done32, 4'b0100);

    // non-sequential bytes split into two words
    do_reset();
    start_dl(8'd0);
    send_byte(25'd0, 8'h5A);
    send_byte(25'd6, 8'hC3);
    tick();
    tick();
    check("ns1_wr", lwr, 4'b0001);
    check("ns1_addr", laddr, 0);
    check("ns1_be", be, 2'b01);
    check("ns1_wdat", wdat, 16'h005A);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    dl = 1'b0;
    tick();
    tick();
    tick();
    check("ns2_wr", lwr, 4'b0001);
    check("ns2_addr", laddr, 3);
    check("ns2_be", be, 2'b01);
    check("ns2_wdat", wdat, 16'h00C3);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    tick();
    check("ns_done", done, 4'b0001);

    // back-pressure: 10 words, honoring wait, drained in order
    do_reset();
    start_dl(8'd3);
    sent       = 0;
    first_wait = -1;
    fork
      begin
        for (int n = 0; n < 10; n++) begin
          for (int b = 0; b < 2; b++) begin
            int guard;
            guard = 0;
            while (wt && guard < 500) begin
              if (first_wait < 0)
                first_wait = sent;
              tick();
              guard++;
            end
            if (guard == 500)
              check("stream_to", wt, 0);
            if (b == 0)
              send_byte(25'(2 * n), 8'(8'h10 + n));
            else
              send_byte(25'(2 * n + 1), 8'(8'h80 + n));
            sent++;
          end
        end
      end
      begin
        for (int k = 0; k < 30; k++)
          tick();
        check("bp_wait", wt, 1);
        check("bp_ovf", ovf, 0);
        for (int n = 0; n < 10; n++) begin
          int cnt;
          cnt = 0;
          while (lwr[3] !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
          end
          check("dr_wr", lwr, 4'b1000);
          check("dr_addr", laddr, 32'(n));
          check("dr_wdat", wdat, {8'(8'h80 + n), 8'(8'h10 + n)});
          ack[3] = 1'b1;
          tick();
          ack[3] = 1'b0;
          tick();
        end
      end
    join
    check("bp_rise", 32'(first_wait), 7);
    dl = 1'b0;
    tick();
    tick();
    check("bp_done", done, 4'b1000);
    check("bp_ovf_end", ovf, 0);

    // invalid channel: bytes discarded, done untouched
    start_dl(8'd7);
    send_byte(25'd0, 8'h01);
    send_byte(25'd1, 8'h02);
    tick();
    tick();
    tick();
    check("inv_wr", lwr, 0);
    check("inv_wait", wt, 0);
    dl = 1'b0;
    tick();
    tick();
    check("inv_done", done, 4'b1000);

    // forced overflow: ignore wait with ack held low
    do_reset();
    start_dl(8'd0);
    for (int n = 0; n < 6; n++) begin
      send_byte(25'(2 * n), 8'(8'h10 + n));
      send_byte(25'(2 * n + 1), 8'(8'h80 + n));
    end
    tick();
    check("of_ovf", ovf, 1);
    check("of_wait", wt, 1);
    check("of_head", wdat, 16'h8010);

    // reset while a request is outstanding
    do_reset();
    start_dl(8'd2);
    send_byte(25'd0, 8'h34);
    send_byte(25'd1, 8'h12);
    tick();
    tick();
    check("mr_wr", lwr, 4'b0100);
    check("mr_wdat", wdat, 16'h1234);
    rstn = 1'b0;
    dl   = 1'b0;
    tick();
    check("mr_rwr", lwr, 0);
    check("mr_rwait", wt, 0);
    check("mr_raddr", laddr, 0);
    check("mr_rwdat", wdat, 0);
    check("mr_rbe", be, 0);
    check("mr_rdone", done, 0);
    check("mr_rovf", ovf, 0);
    rstn   = 1'b1;
    ack[2] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("mr_post_wr", lwr, 0);
    check("mr_post_done", done, 0);
    check("mr_post_wait", wt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
